// File: rtl/bus_arb_pkg.sv
// Shared state encoding and parameter limits for the round-robin bus arbiter.
// Imported by bus_rr_arbiter.
package bus_arb_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_REQ_MIN = 2;
  localparam int unsigned NUM_REQ_MAX = 8;

  function automatic bit num_req_ok(input int unsigned n);
    return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-and-find-first: first set bit of req, searching upward from ptr+1
// with wrap-around.
module rr_priority_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  // Descending scan so the smallest rotation distance wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = int'(N); k >= 1; k--) begin
      pos = IW'((int'(ptr) + k) % int'(N));
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one basil register bus between NUM_REQ masters.
// Define BUS_ARB_LOCK_EN to honour REQ_LOCK (bounded by MAX_LOCK).
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ABUSWIDTH = 16,
  parameter int unsigned MAX_LOCK  = 16
) (
  input  logic                         BUS_CLK,
  input  logic                         BUS_RST_N,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ-1:0]           REQ_WR,
  input  logic [NUM_REQ*ABUSWIDTH-1:0] REQ_ADD,
  input  logic [NUM_REQ*8-1:0]         REQ_DATA,
  input  logic [NUM_REQ-1:0]           REQ_LOCK,
  output logic [NUM_REQ-1:0]           ACK,
  output logic [7:0]                   RD_DATA,
  output logic                         BUSY,
  output logic [ABUSWIDTH-1:0]         BUS_ADD,
  output logic [7:0]                   BUS_DATA_IN,
  output logic                         BUS_RD,
  output logic                         BUS_WR,
  input  logic [7:0]                   BUS_DATA_OUT
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned LW = $clog2(MAX_LOCK + 1);

  generate
    if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
      $error("bus_rr_arbiter: NUM_REQ out of range");
    end
  endgenerate

  arb_state_e           state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gnt;
  logic                 lat_wr;

  logic [NUM_REQ-1:0]   elig;
  logic                 pick_v;
  logic [IW-1:0]        pick_i;
  logic                 lock_hit;
  logic                 go;
  logic [IW-1:0]        win;
  logic [ABUSWIDTH-1:0] sel_add;
  logic [7:0]           sel_data;
  logic                 sel_wr;
  logic [NUM_REQ-1:0]   ack_hot;

  // A requester being acked this cycle must not win again on stale REQ.
  assign elig = REQ & ~ACK;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .valid (pick_v),
    .idx   (pick_i)
  );

`ifdef BUS_ARB_LOCK_EN
  logic [LW-1:0] lock_cnt;

  assign lock_hit = REQ[ptr] & REQ_LOCK[ptr]
                  & (lock_cnt < LW'(MAX_LOCK));

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      lock_cnt <= '0;
    end else if (state == ST_IDLE && go) begin
      lock_cnt <= lock_hit ? lock_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^{REQ_LOCK, LW'(MAX_LOCK)};
  assign lock_hit    = 1'b0;
`endif

  assign go  = lock_hit | pick_v;
  assign win = lock_hit ? ptr : pick_i;

  always_comb begin
    sel_add  = '0;
    sel_data = '0;
    sel_wr   = 1'b0;
    ack_hot  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win == IW'(i)) begin
        sel_add  = REQ_ADD[i*ABUSWIDTH +: ABUSWIDTH];
        sel_data = REQ_DATA[i*8 +: 8];
        sel_wr   = REQ_WR[i];
      end
      ack_hot[i] = (gnt == IW'(i));
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state       <= ST_IDLE;
      ptr         <= IW'(NUM_REQ - 1);
      gnt         <= '0;
      lat_wr      <= 1'b0;
      ACK         <= '0;
      RD_DATA     <= '0;
      BUSY        <= 1'b0;
      BUS_ADD     <= '0;
      BUS_DATA_IN <= '0;
      BUS_RD      <= 1'b0;
      BUS_WR      <= 1'b0;
    end else begin
      ACK <= '0;
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            state       <= ST_ISSUE;
            ptr         <= win;
            gnt         <= win;
            lat_wr      <= sel_wr;
            BUSY        <= 1'b1;
            BUS_ADD     <= sel_add;
            BUS_DATA_IN <= sel_data;
            BUS_RD      <= ~sel_wr;
            BUS_WR      <= sel_wr;
          end
        end
        ST_ISSUE: begin
          state  <= ST_CAPTURE;
          BUS_RD <= 1'b0;
          BUS_WR <= 1'b0;
        end
        ST_CAPTURE: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          ACK   <= ack_hot;
          if (!lat_wr) begin
            RD_DATA <= BUS_DATA_OUT;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
